// File: rtl/fifo_w_compact.sv
// fifo_w_compact: write-side staging stage ahead of the multi-port banked FIFO.
// It compacts a sparse upstream bundle into a prefix-contiguous write set. Any
// entries the FIFO does not ack are held and re-presented (shifted down) on
// later cycles. Upstream stays back-pressured until the whole bundle retires.
//
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_valid         upstream bundle present
//   i_mask          per-lane valid (holes allowed)
//   i_data          per-lane data, lane k = i_data[k]
//   o_ready         bundle taken this cycle when i_valid & o_ready
//   o_w_e           FIFO write enables, ones-then-zeros
//   o_w_data        FIFO write data, lane k = k-th held entry
//   i_w_ack         FIFO acks (expected to be a prefix of o_w_e)
//   i_flush         discard held entries, drop this cycle's input
//   o_held          number of entries currently held

// Per-slot next-value select: flush clears, accept loads, otherwise shift/hold.
module fifo_w_compact_lane #(
  parameter int WIDTH = 32
) (
  input  logic             i_flush,
  input  logic             i_take,
  input  logic [WIDTH-1:0] i_comp,
  input  logic [WIDTH-1:0] i_shft,
  output logic [WIDTH-1:0] o_nxt
);
  assign o_nxt = i_flush ? '0 : (i_take ? i_comp : i_shft);
endmodule

module fifo_w_compact #(
  parameter int WIDTH = 32,
  parameter int LANES = 2,
  localparam int CW   = $clog2(LANES + 1)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  input  logic [LANES-1:0]            i_mask,
  input  logic [LANES-1:0][WIDTH-1:0] i_data,
  output logic                        o_ready,
  output logic [LANES-1:0]            o_w_e,
  output logic [LANES-1:0][WIDTH-1:0] o_w_data,
  input  logic [LANES-1:0]            i_w_ack,
  input  logic                        i_flush,
  output logic [CW-1:0]               o_held
);

  logic [LANES-1:0][WIDTH-1:0] buf_q, buf_d, comp, shft;
  logic [CW-1:0]               cnt_q, cnt_d, acked, rem, n_in;
  logic [LANES-1:0]            w_e;
  logic                        take;

  // Write enables and the retire count. Acks outside o_w_e are ignored,
  // so acked never exceeds cnt_q and rem cannot underflow.
  always_comb begin
    w_e   = '0;
    acked = '0;
    for (int k = 0; k < LANES; k++) begin
      w_e[k] = (CW'(k) < cnt_q);
      acked  = acked + CW'(i_w_ack[k] & w_e[k]);
    end
    rem = cnt_q - acked;
  end

  assign o_ready = ~i_flush & (rem == '0);
  assign take    = i_valid & o_ready;

  // Pack the set mask bits in ascending lane order; n_in tracks the next slot.
  always_comb begin
    comp = '0;
    n_in = '0;
    for (int j = 0; j < LANES; j++) begin
      if (i_mask[j]) begin
        for (int k = 0; k < LANES; k++)
          if (CW'(k) == n_in) comp[k] = i_data[j];
        n_in = n_in + 1'b1;
      end
    end
  end

  // Shift down by acked. Slots above cnt_q are already zero, so the vacated
  // top slots fill with zeros. The sum cannot wrap because 2^CW >= 2*LANES.
  always_comb begin
    shft = '0;
    for (int k = 0; k < LANES; k++)
      for (int j = 0; j < LANES; j++)
        if (CW'(j) == CW'(k) + acked) shft[k] = buf_q[j];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    fifo_w_compact_lane #(.WIDTH(WIDTH)) u_lane (
      .i_flush (i_flush),
      .i_take  (take),
      .i_comp  (comp[k]),
      .i_shft  (shft[k]),
      .o_nxt   (buf_d[k])
    );
  end

  always_comb begin
    cnt_d = rem;
    if (i_flush)   cnt_d = '0;
    else if (take) cnt_d = n_in;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_w_e    = w_e;
  assign o_w_data = buf_q;
  assign o_held   = cnt_q;

endmodule

// File: tb/tb_fifo_w_compact.sv
module tb_fifo_w_compact;
  localparam int W  = 32;
  localparam int L  = 2;
  localparam int CW = $clog2(L + 1);

  logic                i_clk = 1'b0;
  logic                i_rst_n = 1'b0;
  logic                i_valid = 1'b0;
  logic [L-1:0]        i_mask = '0;
  logic [L-1:0][W-1:0] i_data = '0;
  logic                o_ready;
  logic [L-1:0]        o_w_e;
  logic [L-1:0][W-1:0] o_w_data;
  logic [L-1:0]        i_w_ack = '0;
  logic                i_flush = 1'b0;
  logic [CW-1:0]       o_held;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q[$];   // reference: entries still owed to the FIFO, in order

  fifo_w_compact #(.WIDTH(W), .LANES(L)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_mask(i_mask),
    .i_data(i_data), .o_ready(o_ready), .o_w_e(o_w_e), .o_w_data(o_w_data),
    .i_w_ack(i_w_ack), .i_flush(i_flush), .o_held(o_held)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [L-1:0] exp_we;
    exp_we = '0;
    for (int k = 0; k < L; k++) exp_we[k] = (k < q.size());
    chk("held", 64'(o_held), 64'(q.size()));
    chk("w_e", 64'(o_w_e), 64'(exp_we));
    for (int k = 0; k < L; k++)
      chk($sformatf("w_data[%0d]", k), 64'(o_w_data[k]), (k < q.size()) ? 64'(q[k]) : 64'd0);
  endtask

  // One clock cycle: drive, check o_ready, clock, update model, check state.
  task automatic cycle(input logic v, input logic [L-1:0] m, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic [L-1:0] a, input logic f);
    int   acked;
    logic exp_rdy;
    i_valid = v; i_mask = m; i_data[0] = d0; i_data[1] = d1; i_w_ack = a; i_flush = f;
    #1;
    acked = 0;
    for (int k = 0; k < L; k++) if (a[k] && k < q.size()) acked++;
    exp_rdy = !f && (q.size() - acked == 0);
    chk("ready", 64'(o_ready), 64'(exp_rdy));
    @(posedge i_clk);
    if (f) q.delete();
    else if (v && exp_rdy) begin
      q.delete();
      for (int j = 0; j < L; j++) if (m[j]) q.push_back(i_data[j]);
    end else repeat (acked) void'(q.pop_front());
    #1;
    check_state();
  endtask

  initial begin
    logic [L:0] tmp;
    int n;
    // Reset then idle
    #12 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check_state();
    cycle(0, 2'b00, 0, 0, 2'b00, 0);

    // Lane1-only bundle, lands in slot 0; ack it next cycle
    cycle(1, 2'b10, 32'hA, 32'hB, 2'b11, 0);
    chk("lane1_to_slot0", 64'(o_w_data[0]), 64'hB);
    cycle(0, 2'b00, 0, 0, 2'b01, 0);

    // Partial ack: D shifts to slot 0, then last ack with new bundle E,F
    cycle(1, 2'b11, 32'hC, 32'hD, 2'b00, 0);
    cycle(1, 2'b11, 32'hC, 32'hD, 2'b01, 0);
    chk("d_shift", 64'(o_w_data[0]), 64'hD);
    cycle(1, 2'b11, 32'hE, 32'hF, 2'b01, 0);
    chk("ef_held", 64'(o_held), 64'd2);

    // Streaming: one bundle per cycle with full acks
    for (int i = 0; i < 16; i++)
      cycle(1, 2'b11, 32'h100 + 2 * i, 32'h101 + 2 * i, 2'b11, 0);
    cycle(0, 2'b00, 0, 0, 2'b11, 0);

    // FIFO full for 5 cycles, then flush with a valid input
    cycle(1, 2'b11, 32'h55, 32'h66, 2'b00, 0);
    repeat (5) cycle(1, 2'b11, 32'h55, 32'h66, 2'b00, 0);
    cycle(1, 2'b11, 32'h77, 32'h88, 2'b00, 1);
    chk("flush_empty", 64'(o_held), 64'd0);

    // Asynchronous reset mid-retry
    cycle(1, 2'b11, 32'h99, 32'hAA, 2'b00, 0);
    cycle(0, 2'b00, 0, 0, 2'b01, 0);
    #3 i_rst_n = 1'b0;
    #1;
    q.delete();
    check_state();
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    cycle(1, 2'b00, 32'h1, 32'h2, 2'b00, 0);

    // Random traffic including holes, partial acks, stray acks and flushes
    for (int i = 0; i < 300; i++) begin
      n = $urandom_range(0, L);
      tmp = (1 << n) - 1;
      cycle($urandom_range(0, 3) != 0, L'($urandom), $urandom, $urandom,
            ($urandom_range(0, 9) == 0) ? L'($urandom) : tmp[L-1:0],
            $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_w_compact.md
# fifo_w_compact

Write-side staging stage placed directly upstream of the multi-port banked FIFO. Each cycle it takes one upstream bundle of up to LANES entries with an arbitrary (sparse) valid mask, compacts the valid entries into lane order and presents them as a prefix-contiguous write-enable bitmap. It holds whatever the FIFO does not acknowledge and re-presents it on following cycles, back-pressuring upstream until the whole bundle is retired.

## Interface
- WIDTH, 32, data width per entry
- LANES, 2, entries per bundle; equals the FIFO write-port count; power of 2, ≥2
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  upstream bundle present
- i_mask  in  LANES  per-lane valid, any pattern including holes
- i_data  in  WIDTH × [0:LANES-1]  per-lane data
- o_ready  out  1  bundle accepted this cycle when i_valid & o_ready
- o_w_e  out  LANES  FIFO write enables, always prefix-contiguous (ones then zeros)
- o_w_data  out  WIDTH × [0:LANES-1]  FIFO write data, lane k = k-th held entry
- i_w_ack  in  LANES  FIFO acks; a prefix of o_w_e
- i_flush  in  1  pipeline flush; discard held entries
- o_held  out  clog2(LANES+1)  number of entries currently held

## Operation
- State: holding buffer buf[0:LANES-1] plus count cnt (0..LANES). o_w_e[k] = (k < cnt); o_w_data[k] = buf[k]; o_held = cnt. All outputs come straight from registers, except o_ready.
- acked = popcount(i_w_ack & o_w_e). Remaining entries: rem = cnt − acked.
- o_ready = ~i_flush & (rem == 0). This is combinational from i_w_ack. There is no loop, because the FIFO ack depends only on o_w_e.
- Accept (i_valid & o_ready): the set bits of i_mask are packed in ascending lane order into buf[0..n-1], where n = popcount(i_mask). buf[n..LANES-1] is set to 0 and cnt becomes n. A mask of all zeros is accepted and stores nothing (cnt = 0).
- Partial ack (0 < acked < cnt): buf shifts down by acked, the vacated top slots become 0, and cnt becomes rem. No new bundle is accepted in that cycle.
- No ack and no accept: buf and cnt hold.
- i_ack bits outside o_w_e, or a non-prefix i_w_ack, are a protocol violation. The design uses popcount only and must not hang.
- Flush has priority over everything: cnt becomes 0 and buf becomes 0. o_ready is 0, so upstream input in the flush cycle is dropped.
- Reset (asynchronous, any time, including mid-retry): cnt = 0 and buf = 0. Consequently o_w_e = 0, o_w_data = 0, o_held = 0, and o_ready = 1 once reset is released (with i_flush = 0).

## Timing
- Latency: a bundle accepted at the edge ending cycle N is presented on o_w_e in cycle N+1.
- Ack in cycle M retires those entries at the edge ending M. Remaining entries are re-presented, shifted down, in cycle M+1.
- Full ack plus new bundle in the same cycle: o_ready = 1 in M, and the new bundle appears in M+1. This gives back-to-back throughput of one bundle per cycle with no bubble.
- Upstream must hold i_valid, i_mask and i_data stable while o_ready = 0.
- A bundle with k entries and the FIFO acking one per cycle takes k cycles. o_ready rises in the cycle the last entry is acked.

## Test plan
- Reset then idle, LANES=2 → o_w_e=00, o_held=0, o_ready=1, o_w_data all zero.
- i_mask=10 (lane1 only), i_data={A,B}, full ack → next cycle o_w_e=01, o_w_data[0]=B; ack=01 in that cycle → o_held 0 next cycle.
- i_mask=11 {C,D}, ack=01 → o_ready=0, held entry D moves to lane 0; next cycle o_w_e=01 with D; ack=01 → o_ready=1 in that cycle, and a new bundle {E,F} presented then appears the following cycle.
- Bundles of 11 streamed continuously with ack=11 every cycle → one bundle per cycle, o_ready stays 1, and data order is preserved across 16 bundles.
- FIFO full (ack=00) for 5 cycles with 2 held entries, then i_flush=1 while i_valid=1 → o_ready=0 in the flush cycle, o_held=0 next cycle, and the input bundle is not stored.
- i_rst_n asserted low mid-retry with o_held=1 → asynchronously o_w_e=00 and o_held=0; after release, o_ready=1 and a mask of 00 is accepted without presenting writes.
